kpg_serial_subtractor: RTL and testbench

//   Multi-cycle WIDTH-bit subtractor: diff = a - b - bin.

---
 rtl/kpg_pkg.sv | 38 +++
 rtl/kpg_chunk_sub.sv | 41 ++++
 rtl/kpg_serial_subtractor.sv | 182 ++++++++++++++++++
 tb/tb_kpg_serial_subtractor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/kpg_pkg.sv
// -----------------------------------------------------------------------------
// kpg_pkg
//   Shared definitions for the serial KPG subtractor:
//     - ASCII kill/propagate/generate characters used to tag carry status
//     - FSM state encoding
//     - kpg_encode  : per-bit status from a minuend bit and an inverted
//                     subtrahend bit
//     - kpg_combine : prefix operator, "p" passes the lower status through
// -----------------------------------------------------------------------------
package kpg_pkg;

    localparam logic [7:0] KPG_K = 8'h6B;  // "k": carry killed
    localparam logic [7:0] KPG_P = 8'h70;  // "p": carry propagated
    localparam logic [7:0] KPG_G = 8'h67;  // "g": carry generated

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // nb is the already-inverted subtrahend bit, so this is plain adder KPG.
    function automatic logic [7:0] kpg_encode(input logic a, input logic nb);
        logic [7:0] ch;
        if (a & nb)
            ch = KPG_G;
        else if (~a & ~nb)
            ch = KPG_K;
        else
            ch = KPG_P;
        return ch;
    endfunction

    function automatic logic [7:0] kpg_combine(input logic [7:0] hi, input logic [7:0] lo);
        return (hi == KPG_P) ? lo : hi;
    endfunction

endpackage

// File: rtl/kpg_chunk_sub.sv
// -----------------------------------------------------------------------------
// kpg_chunk_sub
//   Combinational CHUNK-bit slice of a + ~b + cin using a serial KPG prefix.
//   The incoming carry is folded in as a "g"/"k" status at the bottom of the
//   prefix chain, so a run of "p" bits resolves to the incoming carry.
//
// Ports
//   i_a    in  CHUNK  minuend slice
//   i_nb   in  CHUNK  inverted subtrahend slice
//   i_cin  in  1      carry into bit 0 of the slice
//   o_sum  out CHUNK  sum slice
//   o_cout out 1      carry out of the slice
// -----------------------------------------------------------------------------
module kpg_chunk_sub
    import kpg_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_nb,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [7:0] w_pref;   // status of everything below the current bit
    logic [7:0] w_bit;    // status of the current bit alone

    always_comb begin
        w_pref = i_cin ? KPG_G : KPG_K;
        w_bit  = KPG_K;
        o_sum  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_bit    = kpg_encode(i_a[i], i_nb[i]);
            o_sum[i] = i_a[i] ^ i_nb[i] ^ (w_pref == KPG_G);
            w_pref   = kpg_combine(w_bit, w_pref);
        end
        o_cout = (w_pref == KPG_G);
    end

endmodule

// File: rtl/kpg_serial_subtractor.sv
// -----------------------------------------------------------------------------
// kpg_serial_subtractor
//   Multi-cycle WIDTH-bit subtractor: diff = a - b - bin (mod 2^WIDTH),
//   computed as a + ~b + ~bin one CHUNK-bit slice per cycle, LSB slice first.
//   WIDTH must be a multiple of CHUNK with at least two slices.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operands presented
//   in_ready   out  1      high only in IDLE
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  registered difference
//   bout       out  1      borrow-out (a < b + bin, unsigned)
//   xout       out  8      final carry status, "g" or "k"
//   zf/nf/vf   out  1      zero/negative/signed-overflow flags
//                          (present only with KPG_SUB_FLAGS_EN defined)
// -----------------------------------------------------------------------------
module kpg_serial_subtractor
    import kpg_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [7:0]       xout
`ifdef KPG_SUB_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf,
    output logic             vf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;      // minuend shifts out, finished slices shift in
    logic [WIDTH-1:0] r_nb;     // inverted subtrahend, shifts out
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic [7:0]       r_xout;

    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_a_next;
    logic             w_accept;
    logic             w_run;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_run    = (r_state == RUN);
    assign w_last   = w_run && (r_idx == LAST_IDX);
    // After the last slice this is the complete difference.
    assign w_a_next = {w_sum, r_a[WIDTH-1:CHUNK]};

    kpg_chunk_sub #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a    (r_a[CHUNK-1:0]),
        .i_nb   (r_nb[CHUNK-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (r_idx == LAST_IDX) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // ---- Operand / carry datapath (no reset needed, reloaded on accept) ----
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a     <= a;
            r_nb    <= ~b;
            r_carry <= ~bin;
        end else if (w_run) begin
            r_a     <= w_a_next;
            r_nb    <= r_nb >> CHUNK;
            r_carry <= w_cout;
        end
    end

    // ---- Slice index and visible results ----
    // The result registers load only on the last slice, so nothing partial
    // ever reaches diff/bout/xout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_xout <= KPG_K;
        end else begin
            if (w_accept)
                r_idx <= '0;
            else if (w_run)
                r_idx <= r_idx + 1'b1;
            if (w_last) begin
                r_diff <= w_a_next;
                r_bout <= ~w_cout;
                r_xout <= w_cout ? KPG_G : KPG_K;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign xout = r_xout;

`ifdef KPG_SUB_FLAGS_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_zf;
    logic r_nf;
    logic r_vf;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf <= 1'b0;
            r_nf <= 1'b0;
            r_vf <= 1'b0;
        end else if (w_last) begin
            r_zf <= (w_a_next == '0);
            r_nf <= w_sum[CHUNK-1];
            r_vf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_sum[CHUNK-1]);
        end
    end

    assign zf = r_zf;
    assign nf = r_nf;
    assign vf = r_vf;
`endif

endmodule

// File: tb/tb_kpg_serial_subtractor.sv
module tb_kpg_serial_subtractor;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam logic [7:0] CH_K = 8'h6B;
    localparam logic [7:0] CH_G = 8'h67;

    typedef struct packed {
        logic [63:0] diff;
        logic        bout;
        logic [7:0]  xout;
        logic        zf;
        logic        nf;
        logic        vf;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic [7:0]       xout;
`ifdef KPG_SUB_FLAGS_EN
    logic             zf;
    logic             nf;
    logic             vf;
`endif

    kpg_serial_subtractor #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .xout      (xout)
`ifdef KPG_SUB_FLAGS_EN
        ,
        .zf        (zf),
        .nf        (nf),
        .vf        (vf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain 65-bit unsigned subtraction, independent of KPG.
    function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin);
        exp_t        e;
        logic [64:0] r;
        r      = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
        e.diff = r[63:0];
        e.bout = r[64];
        e.xout = r[64] ? CH_K : CH_G;
        e.zf   = (r[63:0] == 64'd0);
        e.nf   = r[63];
        e.vf   = (ma[63] ^ mb[63]) & (ma[63] ^ r[63]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] sa, input logic [63:0] sbv, input logic sbin);
        chk("accept_ready", 64'(in_ready), 64'd1);
        a        = sa;
        b        = sbv;
        bin      = sbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = $urandom();
        b        = $urandom();
        sb.push_back(model(sa, sbv, sbin));
    endtask

    // lat = edges already elapsed since (and including) the accept edge.
    task automatic wait_result(input string tag, input int lat0, input bit check_lat);
        int lat;
        lat = lat0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (check_lat)
            chk({tag, "_latency"}, 64'(lat), 64'(NCHUNK + 1));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            cur = sb.pop_front();
            chk({tag, "_diff"}, diff, cur.diff);
            chk({tag, "_bout"}, 64'(bout), 64'(cur.bout));
            chk({tag, "_xout"}, 64'(xout), 64'(cur.xout));
`ifdef KPG_SUB_FLAGS_EN
            chk({tag, "_zf"}, 64'(zf), 64'(cur.zf));
            chk({tag, "_nf"}, 64'(nf), 64'(cur.nf));
            chk({tag, "_vf"}, 64'(vf), 64'(cur.vf));
`endif
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", diff, 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        chk("rst_xout", 64'(xout), 64'(CH_K));

        // 1: simple positive difference, with latency
        send(64'd5, 64'd3, 1'b0);
        wait_result("t1", 1, 1'b1);
        chk("t1_const_diff", diff, 64'd2);
        chk("t1_const_xout", 64'(xout), 64'(CH_G));
        release_out("t1");

        // 2: underflow wraps to all ones
        send(64'd0, 64'd1, 1'b0);
        wait_result("t2", 1, 1'b1);
        chk("t2_const_diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_const_bout", 64'(bout), 64'd1);
        release_out("t2");

        // 3: all-propagate chain resolved only by the borrow-in
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        wait_result("t3", 1, 1'b1);
        chk("t3_const_diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        release_out("t3");

        // 4: requests during RUN/DONE are dropped; DONE held under backpressure
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        tick();
        in_valid = 1'b1;
        a        = 64'd99;
        b        = 64'd1;
        chk("t4_run_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        wait_result("t4", 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            tick();
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_ready", 64'(in_ready), 64'd0);
            chk("t4_hold_diff", diff, cur.diff);
            chk("t4_hold_bout", 64'(bout), 64'(cur.bout));
            chk("t4_hold_xout", 64'(xout), 64'(cur.xout));
        end
        in_valid = 1'b0;
        release_out("t4");
        repeat (NCHUNK + 4) tick();
        chk("t4_no_second_result", 64'(out_valid), 64'd0);

        // 5: reset during RUN chunk 4 aborts cleanly
        send(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_diff", diff, 64'd0);
        chk("t5_xout", 64'(xout), 64'(CH_K));
        send(64'd10, 64'd4, 1'b0);
        wait_result("t5b", 1, 1'b1);
        chk("t5b_const_diff", diff, 64'd6);
        release_out("t5b");

        // Random operands
        for (int i = 0; i < 4; i++) begin
            send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            wait_result("rnd", 1, 1'b1);
            release_out("rnd");
        end

`ifdef KPG_SUB_FLAGS_EN
        // 6: signed overflow and zero flags
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        wait_result("t6", 1, 1'b1);
        chk("t6_const_vf", 64'(vf), 64'd1);
        chk("t6_const_nf", 64'(nf), 64'd0);
        chk("t6_const_zf", 64'(zf), 64'd0);
        release_out("t6");
        send(64'd7, 64'd7, 1'b0);
        wait_result("t6b", 1, 1'b1);
        chk("t6b_const_zf", 64'(zf), 64'd1);
        release_out("t6b");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
